alu_mul_sequencer: RTL and testbench

- Multi-cycle unsigned multiplier controller that reuses the single-cycle ALU's ADD operation (code 4'b0000) via shift-add iteration.
- Sits between the core datapath and the ALU. It owns the ALU input mux: the core drives the ALU while the sequencer is idle; the sequencer drives it while a multiply runs.
- Returns the low WIDTH bits of the product, with a one-cycle DONE pulse.
- Stalls the core for the duration of the multiply.

---
 rtl/alu_mul_sequencer_if.sv | 30 +++
 rtl/alu_mul_sequencer.sv | 94 +++++++++
 tb/tb_alu_mul_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_mul_sequencer_if.sv
// Signal bundle between the core, the ALU and the shift-add multiply sequencer.
// The slave modport is the sequencer's view; the master modport is the core/ALU side.
interface alu_mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic [3:0]       core_op;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_op;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] product;

    modport slave (
        input  start, mul_a, mul_b, core_a, core_b, core_op, alu_result,
        output alu_a, alu_b, alu_op, busy, stall, done, product
    );

    modport master (
        output start, mul_a, mul_b, core_a, core_b, core_op, alu_result,
        input  alu_a, alu_b, alu_op, busy, stall, done, product
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned multiplier that borrows the ALU's ADD for shift-add iteration.
// Owns the ALU input mux: core drives it when idle, the sequencer while a multiply runs.
module alu_mul_sequencer #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    alu_mul_sequencer_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [3:0] OP_ADD = 4'b0000;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc, mcand, mplier, product;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_nxt;
    logic             last;

    // Only add the shifted multiplicand when the current multiplier bit is set.
    assign acc_nxt = mplier[0] ? bus.alu_result : acc;
    assign last    = (cnt == CW'(WIDTH - 1)) ||
                     (EARLY_EXIT && ((mplier >> 1) == '0));

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        bus.alu_a  = bus.core_a;
        bus.alu_b  = bus.core_b;
        bus.alu_op = bus.core_op;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = RUN;
            end
            RUN: begin
                bus.alu_a  = acc;
                bus.alu_b  = mcand;
                bus.alu_op = OP_ADD;
                bus.busy   = 1'b1;
                if (last) state_d = FINISH;
            end
            FINISH: begin
                bus.alu_a  = acc;
                bus.alu_b  = mcand;
                bus.alu_op = OP_ADD;
                bus.busy   = 1'b1;
                bus.done   = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.stall   = bus.busy;
    assign bus.product = product;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mcand  <= bus.mul_a;
                        mplier <= bus.mul_b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // Publish the freshly updated accumulator, not the stale one.
                    if (last) product <= acc_nxt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: one early-exit instance and one fixed-latency instance,
// each paired with a simple behavioural ALU.
module tb_alu_mul_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu_mul_sequencer_if #(.WIDTH(32)) if1 ();
    alu_mul_sequencer_if #(.WIDTH(32)) if0 ();

    // Reference ALU: ADD for op 0000, subtract for anything else.
    assign if1.alu_result = (if1.alu_op == 4'b0000) ? if1.alu_a + if1.alu_b : if1.alu_a - if1.alu_b;
    assign if0.alu_result = (if0.alu_op == 4'b0000) ? if0.alu_a + if0.alu_b : if0.alu_a - if0.alu_b;

    alu_mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    alu_mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start a job on one instance; returns with that instance in its DONE cycle.
    task automatic run_job(input bit sel, input logic [31:0] a, input logic [31:0] b, output int n);
        if1.mul_a = a; if1.mul_b = b;
        if0.mul_a = a; if0.mul_b = b;
        if (sel) if1.start = 1'b1; else if0.start = 1'b1;
        tick();
        if1.start = 1'b0; if0.start = 1'b0;
        n = 0;
        while (!(sel ? if1.done : if0.done) && n < 100) begin
            chk("busy_run",  sel ? if1.busy   : if0.busy,   32'd1);
            chk("aluop_run", sel ? if1.alu_op : if0.alu_op, 32'd0);
            n++;
            tick();
        end
        chk("done_seen",   sel ? if1.done  : if0.done,  32'd1);
        chk("stall_final", sel ? if1.stall : if0.stall, 32'd1);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        if1.start = 0; if0.start = 0;
        if1.mul_a = 0; if1.mul_b = 0; if0.mul_a = 0; if0.mul_b = 0;
        if1.core_a = 32'd7; if1.core_b = 32'd5; if1.core_op = 4'b0110;
        if0.core_a = 32'd7; if0.core_b = 32'd5; if0.core_op = 4'b0110;
        tick(); tick();
        chk("rst_busy",    if1.busy,    32'd0);
        chk("rst_stall",   if1.stall,   32'd0);
        chk("rst_done",    if1.done,    32'd0);
        chk("rst_product", if1.product, 32'd0);
        reset = 1'b0;
        tick();

        // Idle pass-through
        chk("idle_alu_a",  if1.alu_a,  32'd7);
        chk("idle_alu_b",  if1.alu_b,  32'd5);
        chk("idle_alu_op", if1.alu_op, 32'd6);
        chk("idle_busy",   if1.busy,   32'd0);

        // 3*5 with early exit: 3 RUN cycles
        run_job(1'b1, 32'd3, 32'd5, n);
        chk("b_runs",    n,            32'd3);
        chk("b_product", if1.product,  32'd15);
        tick();
        chk("b_done_1cyc", if1.done,   32'd0);
        chk("b_idle_busy", if1.busy,   32'd0);
        chk("b_restore",   if1.alu_op, 32'd6);

        // Back-to-back: START in the first IDLE cycle after FINISH
        run_job(1'b1, 32'd6, 32'd7, n);
        chk("p_product", if1.product, 32'd42);
        tick();
        if1.mul_a = 32'h0001_0000; if1.mul_b = 32'h0001_0000; if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        chk("btb_accepted", if1.busy,    32'd1);
        chk("btb_hold",     if1.product, 32'd42);
        n = 0;
        while (!if1.done && n < 100) begin n++; tick(); end
        chk("btb_done", if1.done, 32'd1);
        chk("btb_runs", n, 32'd17);
        chk("btb_product", if1.product, 32'd0);
        tick();

        // Full-width wrap on both instances
        run_job(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        chk("wrap1_runs",    n,           32'd32);
        chk("wrap1_product", if1.product, 32'd1);
        tick();
        chk("wrap1_1cyc", if1.done, 32'd0);
        run_job(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        chk("wrap0_runs",    n,           32'd32);
        chk("wrap0_product", if0.product, 32'd1);
        tick();
        chk("wrap0_1cyc", if0.done, 32'd0);

        // Zero multiplier
        run_job(1'b1, 32'h1234_5678, 32'd0, n);
        chk("zero1_runs",    n,           32'd1);
        chk("zero1_product", if1.product, 32'd0);
        tick();
        run_job(1'b0, 32'h1234_5678, 32'd0, n);
        chk("zero0_runs",    n,           32'd32);
        chk("zero0_product", if0.product, 32'd0);
        tick();

        // Ignored START two cycles into a 6*7 job
        if1.mul_a = 32'd6; if1.mul_b = 32'd7; if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        tick();
        if1.mul_a = 32'd9; if1.mul_b = 32'd9; if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        n = 2;
        while (!if1.done && n < 100) begin n++; tick(); end
        chk("ign_done",    if1.done,    32'd1);
        chk("ign_runs",    n,           32'd3);
        chk("ign_product", if1.product, 32'd42);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ign_no_done", if1.done, 32'd0);
            chk("ign_no_busy", if1.busy, 32'd0);
        end

        // Reset mid-RUN
        if1.mul_a = 32'd100; if1.mul_b = 32'd200; if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        tick();
        chk("rmid_busy_pre", if1.busy, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rmid_busy",    if1.busy,    32'd0);
        chk("rmid_product", if1.product, 32'd0);
        chk("rmid_alu_a",   if1.alu_a,   32'd7);
        chk("rmid_alu_b",   if1.alu_b,   32'd5);
        chk("rmid_alu_op",  if1.alu_op,  32'd6);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rmid_no_done", if1.done, 32'd0);
        end

        // START coincident with RESET is ignored
        if1.mul_a = 32'd3; if1.mul_b = 32'd3; if1.start = 1'b1; reset = 1'b1;
        tick();
        if1.start = 1'b0; reset = 1'b0;
        chk("rst_start_busy", if1.busy, 32'd0);
        tick();
        chk("rst_start_busy2", if1.busy, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
